// File: rtl/dmem_portb_arbiter_pkg.sv
// Shared types and line geometry for DMEM port B, used by the arbiter, the
// accelerator line reader and the CCD line writer.
package dmem_arb_pkg;

  localparam int DMEM_LINE_ADDR_W = 8;
  localparam int DMEM_LINE_W      = 256;

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_CCD,
    OWN_ACC
  } owner_e;

  // Only meaningful for the two requester encodings.
  function automatic owner_e other_side(input owner_e side);
    return (side == OWN_CCD) ? OWN_ACC : OWN_CCD;
  endfunction

endpackage

// File: rtl/dmem_portb_arbiter_if.sv
// Port-B bundle: CCD write requester, accelerator read requester and the
// dual-port RAM port B. The arbiter takes the slave view.
interface dmem_portb_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_LINE_ADDR_W,
  parameter int DATA_W = DMEM_LINE_W
);

  logic              ccd_req;
  logic [ADDR_W-1:0] ccd_addr;
  logic [DATA_W-1:0] ccd_data;
  logic              ccd_gnt;

  logic              acc_req;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_gnt;
  logic [DATA_W-1:0] acc_rdata;
  logic              acc_rvalid;

  logic [ADDR_W-1:0] ram_addr_b;
  logic [DATA_W-1:0] ram_data_b;
  logic              ram_rden_b;
  logic              ram_wren_b;
  logic [DATA_W-1:0] ram_q_b;

  modport slave (
    input  ccd_req, ccd_addr, ccd_data, acc_req, acc_addr, ram_q_b,
    output ccd_gnt, acc_gnt, acc_rdata, acc_rvalid,
           ram_addr_b, ram_data_b, ram_rden_b, ram_wren_b
  );

  modport master (
    output ccd_req, ccd_addr, ccd_data, acc_req, acc_addr, ram_q_b,
    input  ccd_gnt, acc_gnt, acc_rdata, acc_rvalid,
           ram_addr_b, ram_data_b, ram_rden_b, ram_wren_b
  );

endinterface

// File: rtl/dmem_portb_arbiter_rd_valid_pipe.sv
// Delays each accelerator read grant by the RAM read latency so acc_rvalid
// lines up with q_b; also reports whether any read is still outstanding.
module rd_valid_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic gnt,
  output logic rvalid,
  output logic in_flight
);

  logic [RD_LAT-1:0] stage_q;

  // NOTE: registers use <= so every stage samples the pre-edge value of its
  // neighbour; blocking assignments here would collapse the shift chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= (stage_q << 1) | RD_LAT'(gnt);
    end
  end

  assign rvalid    = stage_q[RD_LAT-1];
  assign in_flight = |stage_q;

endmodule

// File: rtl/dmem_portb_arbiter.sv
// DMEM port-B arbiter: round-robin ownership with bounded bursts between the
// CCD line writer and the accelerator line reader, plus read-valid tracking.
module dmem_portb_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DMEM_LINE_ADDR_W,
  parameter int DATA_W    = DMEM_LINE_W,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_portb_arbiter_if.slave   bus,
  output logic                  busy
);

  localparam int              CNT_W      = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic              own_req, other_req;
  logic              ccd_gnt, acc_gnt;
  logic              acc_rvalid, rd_in_flight;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_rden, cmd_wren;

  // NOTE: reset is synchronous, so it only takes effect on a clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= OWN_IDLE;
      last_q  <= OWN_ACC;
      beat_q  <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    owner_d   = owner_q;
    last_d    = last_q;
    beat_d    = beat_q;
    own_req   = 1'b0;
    other_req = 1'b0;

    case (owner_q)
      OWN_CCD: begin
        own_req   = bus.ccd_req;
        other_req = bus.acc_req;
      end
      OWN_ACC: begin
        own_req   = bus.acc_req;
        other_req = bus.ccd_req;
      end
      default: ;
    endcase

    if (owner_q == OWN_IDLE) begin
      beat_d = '0;
      if (bus.ccd_req && bus.acc_req) begin
        owner_d = other_side(last_q);
      end else if (bus.ccd_req) begin
        owner_d = OWN_CCD;
      end else if (bus.acc_req) begin
        owner_d = OWN_ACC;
      end
    end else if (!own_req) begin
      // Owner went quiet: hand straight over, or release to the bubble state.
      beat_d  = '0;
      last_d  = owner_q;
      owner_d = other_req ? other_side(owner_q) : OWN_IDLE;
    end else if (beat_q == BURST_LAST) begin
      beat_d = '0;
      if (other_req) begin
        owner_d = other_side(owner_q);
        last_d  = owner_q;
      end
    end else begin
      beat_d = beat_q + 1'b1;
    end
  end

  assign ccd_gnt = (owner_q == OWN_CCD) && bus.ccd_req;
  assign acc_gnt = (owner_q == OWN_ACC) && bus.acc_req;

  always_comb begin
    cmd_addr = '0;
    cmd_data = '0;
    cmd_rden = 1'b0;
    cmd_wren = 1'b0;
    if (ccd_gnt) begin
      cmd_addr = bus.ccd_addr;
      cmd_data = bus.ccd_data;
      cmd_wren = 1'b1;
    end else if (acc_gnt) begin
      cmd_addr = bus.acc_addr;
      cmd_rden = 1'b1;
    end
  end

  rd_valid_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_valid_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .gnt      (acc_gnt),
    .rvalid   (acc_rvalid),
    .in_flight(rd_in_flight)
  );

  assign bus.ccd_gnt    = ccd_gnt;
  assign bus.acc_gnt    = acc_gnt;
  assign bus.acc_rvalid = acc_rvalid;
  assign bus.acc_rdata  = bus.ram_q_b;
  assign bus.ram_addr_b = cmd_addr;
  assign bus.ram_data_b = cmd_data;
  assign bus.ram_rden_b = cmd_rden;
  assign bus.ram_wren_b = cmd_wren;

  assign busy = (owner_q != OWN_IDLE) || rd_in_flight;

  // Requesters must hold their command steady until granted (or withdraw it).
  a_ccd_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.ccd_req && !ccd_gnt) |=> (!bus.ccd_req ||
      ($stable(bus.ccd_addr) && $stable(bus.ccd_data))));

  a_acc_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.acc_req && !acc_gnt) |=> (!bus.acc_req || $stable(bus.acc_addr)));

  a_one_strobe: assert property (@(posedge clk) disable iff (!rst_n)
    !(cmd_rden && cmd_wren));

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// Randomised scoreboard bench for dmem_portb_arbiter: a cycle-level reference
// model predicts grants/commands, a separate monitor checks read returns.
module tb_dmem_portb_arbiter;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 256;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 4;
  localparam int CMD_W     = ADDR_W + DATA_W + 2;

  localparam int SIDE_NONE = 0;
  localparam int SIDE_CCD  = 1;
  localparam int SIDE_ACC  = 2;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } rd_item_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  dmem_portb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  dmem_portb_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RD_LAT   (RD_LAT),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- RAM port-B model ----------------
  logic [DATA_W-1:0] ram_mem [256];
  logic [DATA_W-1:0] q_pipe  [RD_LAT];

  always @(posedge clk) begin
    if (bus_if.ram_wren_b) ram_mem[bus_if.ram_addr_b] <= bus_if.ram_data_b;
    q_pipe[0] <= bus_if.ram_rden_b ? ram_mem[bus_if.ram_addr_b] : '0;
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign bus_if.ram_q_b = q_pipe[RD_LAT-1];

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ref_mem [256];
  rd_item_t          rd_q [$];
  bit                live = 1'b0;
  int m_owner, m_run, m_last, last_acc_cyc;
  int n_owner = SIDE_NONE, n_run = 0, n_last = SIDE_ACC;

  always @(negedge clk) begin
    bit                exp_c, exp_a, exp_busy;
    bit                req [3];
    int                other;
    logic [CMD_W-1:0]  exp_cmd, act_cmd;
    if (live) begin
      req[SIDE_NONE] = 1'b0;
      req[SIDE_CCD]  = bus_if.ccd_req;
      req[SIDE_ACC]  = bus_if.acc_req;
      exp_c = (m_owner == SIDE_CCD) && req[SIDE_CCD];
      exp_a = (m_owner == SIDE_ACC) && req[SIDE_ACC];
      exp_cmd = '0;
      if (exp_c) exp_cmd = {bus_if.ccd_addr, bus_if.ccd_data, 1'b0, 1'b1};
      if (exp_a) exp_cmd = {bus_if.acc_addr, {DATA_W{1'b0}}, 1'b1, 1'b0};
      act_cmd = {bus_if.ram_addr_b, bus_if.ram_data_b, bus_if.ram_rden_b, bus_if.ram_wren_b};
      exp_busy = (m_owner != SIDE_NONE) ||
                 ((cyc - last_acc_cyc) >= 1 && (cyc - last_acc_cyc) <= RD_LAT);

      check("grants", {bus_if.ccd_gnt, bus_if.acc_gnt}, {exp_c, exp_a});
      check("ram_cmd", act_cmd, exp_cmd);
      check("busy", busy, exp_busy);

      if (exp_c) ref_mem[bus_if.ccd_addr] = bus_if.ccd_data;
      if (exp_a) begin
        rd_q.push_back('{data: ref_mem[bus_if.acc_addr], due: cyc + RD_LAT});
        last_acc_cyc = cyc;
      end

      // Ownership rules: tie-break away from the last served side, burst cap,
      // zero-bubble handover when the other side is waiting.
      n_owner = m_owner; n_run = m_run; n_last = m_last;
      if (m_owner == SIDE_NONE) begin
        if (req[SIDE_CCD] && req[SIDE_ACC]) n_owner = (m_last == SIDE_CCD) ? SIDE_ACC : SIDE_CCD;
        else if (req[SIDE_CCD])             n_owner = SIDE_CCD;
        else if (req[SIDE_ACC])             n_owner = SIDE_ACC;
        n_run = 0;
      end else begin
        other = (m_owner == SIDE_CCD) ? SIDE_ACC : SIDE_CCD;
        if (!req[m_owner]) begin
          n_last  = m_owner;
          n_run   = 0;
          n_owner = req[other] ? other : SIDE_NONE;
        end else if (m_run + 1 == MAX_BURST) begin
          n_run = 0;
          if (req[other]) begin
            n_owner = other;
            n_last  = m_owner;
          end
        end else begin
          n_run = m_run + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      live         = 1'b1;
      m_owner      = SIDE_NONE;
      m_run        = 0;
      m_last       = SIDE_ACC;
      last_acc_cyc = -100;
      rd_q.delete();
    end else begin
      m_owner = n_owner;
      m_run   = n_run;
      m_last  = n_last;
    end
    cyc++;
  end

  // ---------------- read-return monitor ----------------
  always @(negedge clk) begin
    bit       exp_rv;
    rd_item_t it;
    if (live) begin
      exp_rv = (rd_q.size() > 0) && (rd_q[0].due == cyc);
      check("acc_rvalid", bus_if.acc_rvalid, exp_rv);
      if (exp_rv) begin
        it = rd_q.pop_front();
        if (bus_if.acc_rvalid) check("acc_rdata", bus_if.acc_rdata, it.data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic ccd_issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit g = 1'b0;
    bus_if.ccd_req  = 1'b1;
    bus_if.ccd_addr = a;
    bus_if.ccd_data = d;
    for (int n = 0; n < 64 && !g; n++) begin
      @(negedge clk);
      g = bus_if.ccd_gnt;
      step();
    end
    if (!g) begin
      checks++; failures++;
      $display("FAIL ccd_grant_timeout cycle=%0d got=no_grant want=grant", cyc);
    end
  endtask

  task automatic acc_issue(input logic [ADDR_W-1:0] a);
    bit g = 1'b0;
    bus_if.acc_req  = 1'b1;
    bus_if.acc_addr = a;
    for (int n = 0; n < 64 && !g; n++) begin
      @(negedge clk);
      g = bus_if.acc_gnt;
      step();
    end
    if (!g) begin
      checks++; failures++;
      $display("FAIL acc_grant_timeout cycle=%0d got=no_grant want=grant", cyc);
    end
  endtask

  task automatic ccd_rand(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) != 0) ccd_issue(ADDR_W'($urandom_range(0, 15)), rand_line());
      else begin bus_if.ccd_req = 1'b0; step(); end
    end
    bus_if.ccd_req = 1'b0;
  endtask

  task automatic acc_rand(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) != 0) acc_issue(ADDR_W'($urandom_range(0, 15)));
      else begin bus_if.acc_req = 1'b0; step(); end
    end
    bus_if.acc_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < RD_LAT; i++) q_pipe[i] = '0;
    rst_n           = 1'b0;
    bus_if.ccd_req  = 1'b0;
    bus_if.ccd_addr = '0;
    bus_if.ccd_data = '0;
    bus_if.acc_req  = 1'b0;
    bus_if.acc_addr = '0;
    repeat (2) step();
    rst_n = 1'b1;

    // Single-requester burst from idle, then a read of a freshly written line.
    for (int i = 0; i < 3; i++) ccd_issue(ADDR_W'(8'h10 + i), rand_line());
    bus_if.ccd_req = 1'b0;
    step();
    ccd_issue(8'h20, rand_line());
    bus_if.ccd_req = 1'b0;
    step();
    acc_issue(8'h20);
    bus_if.acc_req = 1'b0;
    repeat (4) step();

    // Both sides saturated: alternating bursts capped at MAX_BURST.
    fork
      begin
        for (int i = 0; i < 12; i++) ccd_issue(ADDR_W'(8'h40 + i), rand_line());
        bus_if.ccd_req = 1'b0;
      end
      begin
        for (int i = 0; i < 12; i++) acc_issue(ADDR_W'(8'h40 + i));
        bus_if.acc_req = 1'b0;
      end
    join
    repeat (4) step();

    // Early CCD release while the accelerator waits.
    fork
      begin
        for (int i = 0; i < 2; i++) ccd_issue(ADDR_W'(8'h50 + i), rand_line());
        bus_if.ccd_req = 1'b0;
      end
      begin
        for (int i = 0; i < 3; i++) acc_issue(ADDR_W'(8'h50 + i));
        bus_if.acc_req = 1'b0;
      end
    join
    repeat (4) step();

    // Back-to-back reads with a write landing in the return window.
    fork
      begin
        for (int i = 0; i < 3; i++) acc_issue(ADDR_W'(8'h10 + i));
        bus_if.acc_req = 1'b0;
      end
      begin
        repeat (2) step();
        ccd_issue(8'h30, rand_line());
        bus_if.ccd_req = 1'b0;
      end
    join
    step();
    acc_issue(8'h30);
    bus_if.acc_req = 1'b0;
    repeat (4) step();

    // Reset with reads in flight, then a tie from idle.
    acc_issue(8'h11);
    acc_issue(8'h12);
    bus_if.acc_req = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    fork
      begin ccd_issue(8'h60, rand_line()); bus_if.ccd_req = 1'b0; end
      begin acc_issue(8'h60); bus_if.acc_req = 1'b0; end
    join
    repeat (4) step();

    // Randomised traffic on a small address window to exercise address reuse.
    fork
      ccd_rand(300);
      acc_rand(300);
    join
    repeat (RD_LAT + 4) step();
    check("reads_drained", 32'(rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
